// File: rtl/regfile_we_sweep_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot write-enable decoder for a register file,
// with a hardware clear sweep that pulses every decodable enable once, in ascending order.
module regfile_we_sweep_decoder #(
    parameter int SEL_W     = 5,
    parameter bit ZERO_MASK = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  clr_start,
    output logic [2**SEL_W-1:0]   out,
    output logic                  busy,
    output logic                  done
);

    localparam int               N     = 2**SEL_W;
    localparam logic [SEL_W-1:0] FIRST = ZERO_MASK ? SEL_W'(1) : SEL_W'(0);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     out_q, out_d;
    logic             done_q, done_d;

    // Bit 0 is hard-wired off when the register file has a constant $zero.
    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N-1:0] v;
        v = {{(N-1){1'b0}}, 1'b1} << idx;
        if (ZERO_MASK) v[0] = 1'b0;
        return v;
    endfunction

    // NOTE: async reset clears every register, so an interrupted sweep can never resume;
    // non-blocking assignments keep all registers updating together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    // NOTE: defaults first in every comb block so no path leaves a variable unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (clr_start)     state_d = SWEEP;
            SWEEP:   if (cnt_q == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // clr_start outranks en in IDLE; all inputs are ignored during SWEEP.
    always_comb begin
        cnt_d  = cnt_q;
        out_d  = '0;
        done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_start) begin
                    cnt_d = FIRST;
                end else if (en) begin
                    out_d = onehot(sel);
                end
            end
            SWEEP: begin
                out_d = onehot(cnt_q);
                if (cnt_q == LAST) begin
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + SEL_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign out  = out_q;
    assign done = done_q;
    assign busy = (state_q == SWEEP);

endmodule

// File: tb/tb_regfile_we_sweep_decoder.sv
// Directed bench for regfile_we_sweep_decoder: a behavioural model pushes expected
// outputs into a scoreboard queue on each drive; they are popped and compared after the edge.
module tb_regfile_we_sweep_decoder;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [4:0]  sel;
    logic        clr_start;
    logic [31:0] out_a, out_b;
    logic        busy_a, busy_b, done_a, done_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] out_a;
        logic        busy_a;
        logic        done_a;
        logic [31:0] out_b;
        logic        busy_b;
        logic        done_b;
    } exp_t;

    exp_t sb[$];

    // Model state: index 0 models ZERO_MASK=1, index 1 models ZERO_MASK=0.
    bit m_sweep[2];
    int m_cnt[2];

    logic [31:0] last_exp_out;
    int          busy_cnt_a, busy_cnt_b, done_cnt_a, done_cnt_b;

    regfile_we_sweep_decoder #(.SEL_W(5), .ZERO_MASK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .clr_start(clr_start),
        .out(out_a), .busy(busy_a), .done(done_a)
    );

    regfile_we_sweep_decoder #(.SEL_W(5), .ZERO_MASK(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .clr_start(clr_start),
        .out(out_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int k, input bit e, input int s, input bit c,
                              output logic [31:0] o, output logic b, output logic d);
        int first;
        first = (k == 0) ? 1 : 0;
        o = 32'h0;
        d = 1'b0;
        if (!m_sweep[k]) begin
            if (c) begin
                m_sweep[k] = 1'b1;
                m_cnt[k]   = first;
            end else if (e && !(k == 0 && s == 0)) begin
                o = 32'h1 << s;
            end
        end else begin
            o = 32'h1 << m_cnt[k];
            if (m_cnt[k] == 31) begin
                m_sweep[k] = 1'b0;
                d = 1'b1;
            end else begin
                m_cnt[k]++;
            end
        end
        b = m_sweep[k];
    endtask

    task automatic model_reset();
        m_sweep[0] = 1'b0;
        m_sweep[1] = 1'b0;
        m_cnt[0]   = 0;
        m_cnt[1]   = 0;
        sb.delete();
    endtask

    task automatic cycle(input bit e, input int s, input bit c);
        exp_t x;
        exp_t y;
        @(negedge clk);
        en        = e;
        sel       = 5'(s);
        clr_start = c;
        model_step(0, e, s, c, x.out_a, x.busy_a, x.done_a);
        model_step(1, e, s, c, x.out_b, x.busy_b, x.done_b);
        sb.push_back(x);
        @(posedge clk);
        #1;
        y = sb.pop_front();
        last_exp_out = y.out_a;
        check("out_zm",   out_a,            y.out_a);
        check("busy_zm",  32'(busy_a),      32'(y.busy_a));
        check("done_zm",  32'(done_a),      32'(y.done_a));
        check("out_nz",   out_b,            y.out_b);
        check("busy_nz",  32'(busy_b),      32'(y.busy_b));
        check("done_nz",  32'(done_b),      32'(y.done_b));
        check("onehot0_zm", 32'($onehot0(out_a)), 32'd1);
        check("onehot0_nz", 32'($onehot0(out_b)), 32'd1);
        busy_cnt_a += int'(busy_a);
        busy_cnt_b += int'(busy_b);
        done_cnt_a += int'(done_a);
        done_cnt_b += int'(done_b);
    endtask

    task automatic clear_counts();
        busy_cnt_a = 0;
        busy_cnt_b = 0;
        done_cnt_a = 0;
        done_cnt_b = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_zm"},  out_a,        32'h0);
        check({tag, "_busy_zm"}, 32'(busy_a),  32'h0);
        check({tag, "_done_zm"}, 32'(done_a),  32'h0);
        check({tag, "_out_nz"},  out_b,        32'h0);
        check({tag, "_busy_nz"}, 32'(busy_b),  32'h0);
        check({tag, "_done_nz"}, 32'(done_b),  32'h0);
    endtask

    initial begin
        bit found;

        // Reset held with en active: outputs stay cleared.
        rst_n     = 1'b0;
        en        = 1'b1;
        sel       = 5'd5;
        clr_start = 1'b0;
        model_reset();
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        cycle(1'b0, 0, 1'b0);

        // Normal decode, then zero-mask behaviour on index 0.
        cycle(1'b1, 5, 1'b0);
        cycle(1'b1, 13, 1'b0);
        cycle(1'b1, 31, 1'b0);
        cycle(1'b0, 0, 1'b0);
        cycle(1'b1, 0, 1'b0);
        cycle(1'b1, 1, 1'b0);
        cycle(1'b0, 0, 1'b0);

        // Full sweep.
        clear_counts();
        cycle(1'b0, 0, 1'b1);
        for (int i = 0; i < 36; i++) cycle(1'b0, 0, 1'b0);
        check("sweep_busy_cycles_zm", 32'(busy_cnt_a), 32'd31);
        check("sweep_busy_cycles_nz", 32'(busy_cnt_b), 32'd32);
        check("sweep_done_pulses_zm", 32'(done_cnt_a), 32'd1);
        check("sweep_done_pulses_nz", 32'(done_cnt_b), 32'd1);

        // clr_start wins over en; mid-sweep requests are ignored.
        clear_counts();
        cycle(1'b1, 7, 1'b1);
        for (int i = 0; i < 36; i++) begin
            if (i == 10) cycle(1'b1, 3, 1'b1);
            else         cycle(1'b0, 0, 1'b0);
        end
        check("collide_busy_cycles_zm", 32'(busy_cnt_a), 32'd31);
        check("collide_done_pulses_zm", 32'(done_cnt_a), 32'd1);
        check("collide_done_pulses_nz", 32'(done_cnt_b), 32'd1);

        // Asynchronous reset mid-sweep, while out shows index 10.
        found = 1'b0;
        cycle(1'b0, 0, 1'b1);
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, 0, 1'b0);
            if (last_exp_out == 32'h400) found = 1'b1;
        end
        check("midsweep_reached_0x400", 32'(found), 32'd1);
        check("midsweep_pre_out_zm", out_a, 32'h400);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midsweep_reset");
        model_reset();
        @(negedge clk);
        en        = 1'b0;
        clr_start = 1'b0;
        rst_n     = 1'b1;
        clear_counts();
        for (int i = 0; i < 6; i++) cycle(1'b0, 0, 1'b0);
        check("no_resume_busy_zm", 32'(busy_cnt_a), 32'd0);
        check("no_resume_busy_nz", 32'(busy_cnt_b), 32'd0);
        cycle(1'b1, 9, 1'b0);
        cycle(1'b0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
